// File: rtl/pattern_gen.sv
// rtl/pattern_gen.sv - burst pattern generator feeding a downstream memory stage
//
// Purpose: on in_start (sampled in IDLE only) latch a pattern mode and word
// count, then emit one word per WRITE/WAIT_ACK handshake: out_wrt_en strobes
// for one cycle with out_data held until the memory stage returns in_wrt_rd.
// A one-cycle out_done pulse marks the end of every burst.
//
// Optional feature: define PATTERN_GEN_TIMEOUT_EN to abort a burst when the
// acknowledge does not arrive within TIMEOUT_CYC cycles (sets out_timeout).
//
// Ports:
//   in_clk       clock, rising edge
//   in_rst       synchronous active-high reset
//   in_start     begin a burst (ignored while busy)
//   in_mode      pattern select: 0 counter, 1 walking one, 2 LFSR, 3 alternating
//   in_count     words in the burst; 0 finishes without writing
//   in_wrt_rd    write acknowledge from the memory stage
//   out_data     current pattern word (registered)
//   out_wrt_en   one-cycle write strobe
//   out_busy     high whenever the FSM is not in IDLE
//   out_done     one-cycle end-of-burst pulse
//   out_timeout  sticky acknowledge-timeout flag (0 unless the timeout is built)

module pattern_gen #(
    parameter int DATA_W      = 6,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_start,
    input  logic [1:0]        in_mode,
    input  logic [7:0]        in_count,
    input  logic              in_wrt_rd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_wrt_en,
    output logic              out_busy,
    output logic              out_done,
    output logic              out_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        WAIT_ACK,
        DONE
    } state_t;

    state_t     state;
    logic [1:0] mode_q;
    logic [7:0] rem_cnt;

    // First word of each pattern.
    function automatic logic [DATA_W-1:0] seed_of(input logic [1:0] m);
        logic [DATA_W-1:0] s;
        s = '0;
        case (m)
            2'd0:       s = '0;
            2'd1, 2'd2: s[0] = 1'b1;
            default: begin
                // 1010...10: odd bit positions set
                for (int i = 1; i < DATA_W; i += 2) s[i] = 1'b1;
            end
        endcase
        return s;
    endfunction

    // Word that follows d in pattern m.
    function automatic logic [DATA_W-1:0] next_of(input logic [1:0] m,
                                                  input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] n;
        case (m)
            2'd0:    n = d + DATA_W'(1);
            2'd1:    n = {d[DATA_W-2:0], d[DATA_W-1]};
            2'd2:    n = {d[DATA_W-2:0], d[DATA_W-1] ^ d[DATA_W-2]};
            default: n = ~d;
        endcase
        return n;
    endfunction

`ifdef PATTERN_GEN_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             timeout_q;

    assign out_timeout = timeout_q;
`else
    // Without the timeout WAIT_ACK waits forever; TIMEOUT_CYC has no effect
    // and the flag is a constant low.
    assign out_timeout = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state      <= IDLE;
            mode_q     <= 2'd0;
            rem_cnt    <= 8'd0;
            out_data   <= '0;
            out_wrt_en <= 1'b0;
            out_busy   <= 1'b0;
            out_done   <= 1'b0;
`ifdef PATTERN_GEN_TIMEOUT_EN
            tmo_cnt    <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            // Strobe and done are single-cycle unless re-armed below.
            out_wrt_en <= 1'b0;
            out_done   <= 1'b0;

            case (state)
                IDLE: begin
                    if (in_start) begin
                        mode_q   <= in_mode;
                        rem_cnt  <= in_count;
                        out_data <= seed_of(in_mode);
                        out_busy <= 1'b1;
`ifdef PATTERN_GEN_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                        // An empty burst goes straight to DONE, so rem_cnt
                        // is never decremented from zero.
                        if (in_count == 8'd0) begin
                            state <= DONE;
                        end else begin
                            state      <= WRITE;
                            out_wrt_en <= 1'b1;
                        end
                    end
                end

                WRITE: begin
                    state <= WAIT_ACK;
`ifdef PATTERN_GEN_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end

                WAIT_ACK: begin
                    if (in_wrt_rd) begin
                        out_data <= next_of(mode_q, out_data);
                        rem_cnt  <= rem_cnt - 8'd1;
                        if (rem_cnt == 8'd1) begin
                            state <= DONE;
                        end else begin
                            state      <= WRITE;
                            out_wrt_en <= 1'b1;
                        end
                    end
`ifdef PATTERN_GEN_TIMEOUT_EN
                    // Counter holds 0..TIMEOUT_CYC-1 over the WAIT_ACK cycles;
                    // the last of those without an ack abandons the burst.
                    else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        timeout_q <= 1'b1;
                        state     <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end

                DONE: begin
                    out_done <= 1'b1;
                    out_busy <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_gen.sv
// tb/tb_pattern_gen.sv - scoreboard testbench for pattern_gen

module tb_pattern_gen;

    logic       in_clk = 1'b0;
    logic       in_rst;
    logic       in_start;
    logic [1:0] in_mode;
    logic [7:0] in_count;
    logic       in_wrt_rd;
    logic [5:0] out_data;
    logic       out_wrt_en;
    logic       out_busy;
    logic       out_done;
    logic       out_timeout;

    pattern_gen #(
        .DATA_W      (6),
        .TIMEOUT_CYC (15)
    ) dut (
        .in_clk      (in_clk),
        .in_rst      (in_rst),
        .in_start    (in_start),
        .in_mode     (in_mode),
        .in_count    (in_count),
        .in_wrt_rd   (in_wrt_rd),
        .out_data    (out_data),
        .out_wrt_en  (out_wrt_en),
        .out_busy    (out_busy),
        .out_done    (out_done),
        .out_timeout (out_timeout)
    );

    always #5 in_clk = ~in_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge in_clk) cyc <= cyc + 1;

    logic [5:0] exp_q[$];
    logic [5:0] seen_q[$];
    int         strb_cyc_q[$];
    int         n_strb   = 0;
    int         n_done   = 0;
    int         done_cyc = 0;
    int         start_cyc = 0;
    bit         withhold  = 1'b0;
    bit         stray_ack = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory stage model: ack in the cycle after each strobe.
    initial begin : responder
        bit strb_d;
        strb_d    = 1'b0;
        in_wrt_rd = 1'b0;
        forever begin
            @(posedge in_clk);
            #1;
            in_wrt_rd = (strb_d && !withhold) || stray_ack;
            strb_d    = out_wrt_en;
        end
    end

    // Monitor: pops the scoreboard on every strobe.
    initial begin : monitor
        logic [5:0] e;
        logic [5:0] last_strb;
        bit         prev_strb;
        prev_strb = 1'b0;
        last_strb = '0;
        forever begin
            @(negedge in_clk);
            if (out_wrt_en) begin
                n_strb++;
                strb_cyc_q.push_back(cyc);
                seen_q.push_back(out_data);
                last_strb = out_data;
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", int'(out_data), int'(e));
                end
            end
            if (in_wrt_rd && prev_strb && !in_rst)
                chk("data_hold", int'(out_data), int'(last_strb));
            prev_strb = out_wrt_en;
            if (out_done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_burst(input logic [1:0] m, input logic [7:0] c);
        @(negedge in_clk);
        in_mode   = m;
        in_count  = c;
        in_start  = 1'b1;
        start_cyc = cyc;
        @(negedge in_clk);
        in_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (!out_done && n < budget) begin
            @(negedge in_clk);
            n++;
        end
        if (!out_done) chk({name, "_done_wait"}, 0, 1);
    endtask

    task automatic wait_strb(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (n_strb < target && n < budget) begin
            @(negedge in_clk);
            n++;
        end
        if (n_strb < target) chk({name, "_strobe_wait"}, n_strb, target);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int d0, s0, base, tmo_cyc;
        logic [5:0] lf;
        logic [63:0] mask;
        int ndist;

        in_rst   = 1'b1;
        in_start = 1'b0;
        in_mode  = 2'd0;
        in_count = 8'd0;
        repeat (3) @(negedge in_clk);
        chk("rst_data",    int'(out_data), 0);
        chk("rst_wrt_en",  int'(out_wrt_en), 0);
        chk("rst_busy",    int'(out_busy), 0);
        chk("rst_done",    int'(out_done), 0);
        chk("rst_timeout", int'(out_timeout), 0);
        in_rst = 1'b0;
        repeat (2) @(negedge in_clk);

        // mode 0, count 4: 0,1,2,3, strobes two cycles apart
        for (int i = 0; i < 4; i++) exp_q.push_back(6'(i));
        d0   = n_done;
        base = strb_cyc_q.size();
        start_burst(2'd0, 8'd4);
        chk("m0_busy_run", int'(out_busy), 1);
        wait_done(40, "m0");
        chk("m0_busy_at_done", int'(out_busy), 0);
        @(negedge in_clk);
        chk("m0_done_count", n_done - d0, 1);
        chk("m0_done_width", int'(out_done), 0);
        chk("m0_strobes", strb_cyc_q.size() - base, 4);
        for (int i = 1; i < 4; i++)
            if (strb_cyc_q.size() > base + i)
                chk("m0_gap", strb_cyc_q[base + i] - strb_cyc_q[base + i - 1], 2);
        chk("m0_queue_empty", exp_q.size(), 0);

        // mode 1, count 8: walking one wraps after bit 5
        exp_q.push_back(6'd1);  exp_q.push_back(6'd2);  exp_q.push_back(6'd4);
        exp_q.push_back(6'd8);  exp_q.push_back(6'd16); exp_q.push_back(6'd32);
        exp_q.push_back(6'd1);  exp_q.push_back(6'd2);
        start_burst(2'd1, 8'd8);
        wait_done(60, "m1");
        @(negedge in_clk);
        chk("m1_queue_empty", exp_q.size(), 0);

        // mode 3, count 3: 101010, 010101, 101010
        exp_q.push_back(6'd42); exp_q.push_back(6'd21); exp_q.push_back(6'd42);
        start_burst(2'd3, 8'd3);
        wait_done(40, "m3");
        @(negedge in_clk);
        chk("m3_queue_empty", exp_q.size(), 0);

        // mode 2, count 63: full LFSR cycle
        lf = 6'b000001;
        for (int i = 0; i < 63; i++) begin
            exp_q.push_back(lf);
            lf = {lf[4:0], lf[5] ^ lf[4]};
        end
        base = seen_q.size();
        start_burst(2'd2, 8'd63);
        wait_done(300, "m2");
        @(negedge in_clk);
        chk("m2_queue_empty", exp_q.size(), 0);
        mask  = '0;
        ndist = 0;
        for (int i = base; i < seen_q.size(); i++) begin
            if (seen_q[i] != 6'd0 && !mask[seen_q[i]]) ndist++;
            mask[seen_q[i]] = 1'b1;
        end
        chk("m2_distinct_nonzero", ndist, 63);
        if (seen_q.size() > base) chk("m2_first", int'(seen_q[base]), 1);

        // count 0: no strobe, done two cycles after start
        d0 = n_done;
        s0 = n_strb;
        start_burst(2'd0, 8'd0);
        wait_done(10, "c0");
        @(negedge in_clk);
        chk("c0_done_count", n_done - d0, 1);
        chk("c0_done_latency", done_cyc - start_cyc, 2);
        chk("c0_no_strobe", n_strb - s0, 0);

        // stray ack in IDLE is ignored
        s0 = n_strb;
        stray_ack = 1'b1;
        repeat (4) @(negedge in_clk);
        chk("stray_busy", int'(out_busy), 0);
        stray_ack = 1'b0;
        repeat (2) @(negedge in_clk);
        chk("stray_no_strobe", n_strb - s0, 0);

        // start pulsed mid-burst has no effect
        for (int i = 0; i < 5; i++) exp_q.push_back(6'(i));
        d0 = n_done;
        s0 = n_strb;
        start_burst(2'd0, 8'd5);
        wait_strb(s0 + 2, 20, "mid");
        in_mode  = 2'd1;
        in_count = 8'd2;
        in_start = 1'b1;
        @(negedge in_clk);
        in_start = 1'b0;
        wait_done(40, "mid");
        @(negedge in_clk);
        chk("mid_done_count", n_done - d0, 1);
        chk("mid_strobes", n_strb - s0, 5);
        chk("mid_queue_empty", exp_q.size(), 0);
        repeat (2) @(negedge in_clk);
        chk("mid_no_restart", int'(out_busy), 0);

        // reset during WAIT_ACK aborts with no done
        withhold = 1'b1;
        exp_q.push_back(6'd0);
        d0 = n_done;
        s0 = n_strb;
        start_burst(2'd0, 8'd3);
        @(negedge in_clk);
        in_rst = 1'b1;
        @(negedge in_clk);
        chk("rst2_data",    int'(out_data), 0);
        chk("rst2_wrt_en",  int'(out_wrt_en), 0);
        chk("rst2_busy",    int'(out_busy), 0);
        chk("rst2_done",    int'(out_done), 0);
        chk("rst2_timeout", int'(out_timeout), 0);
        in_rst   = 1'b0;
        withhold = 1'b0;
        repeat (5) @(negedge in_clk);
        chk("rst2_no_done", n_done - d0, 0);
        chk("rst2_strobes", n_strb - s0, 1);
        chk("rst2_queue_empty", exp_q.size(), 0);

`ifdef PATTERN_GEN_TIMEOUT_EN
        // mode 1, count 3, ack withheld on word 2 -> timeout
        exp_q.push_back(6'd1);
        exp_q.push_back(6'd2);
        d0   = n_done;
        s0   = n_strb;
        base = strb_cyc_q.size();
        start_burst(2'd1, 8'd3);
        wait_strb(s0 + 1, 10, "tmo");
        @(negedge in_clk);
        withhold = 1'b1;
        tmo_cyc  = 0;
        for (int n = 0; n < 40 && !out_timeout; n++) @(negedge in_clk);
        if (!out_timeout) chk("tmo_flag_wait", 0, 1);
        else tmo_cyc = cyc;
        if (strb_cyc_q.size() > base + 1)
            chk("tmo_latency", tmo_cyc - strb_cyc_q[base + 1], 16);
        wait_done(10, "tmo");
        @(negedge in_clk);
        withhold = 1'b0;
        chk("tmo_done_count", n_done - d0, 1);
        chk("tmo_strobes", n_strb - s0, 2);
        chk("tmo_sticky", int'(out_timeout), 1);
        exp_q.push_back(6'd0);
        start_burst(2'd0, 8'd1);
        chk("tmo_cleared", int'(out_timeout), 0);
        wait_done(20, "tmo2");
        @(negedge in_clk);
        chk("tmo_queue_empty", exp_q.size(), 0);
`else
        // ack withheld: WAIT_ACK waits indefinitely, flag stays low
        exp_q.push_back(6'd1);
        exp_q.push_back(6'd2);
        exp_q.push_back(6'd4);
        d0 = n_done;
        s0 = n_strb;
        start_burst(2'd1, 8'd3);
        wait_strb(s0 + 1, 10, "hold");
        @(negedge in_clk);
        withhold = 1'b1;
        wait_strb(s0 + 2, 10, "hold");
        repeat (20) @(negedge in_clk);
        chk("hold_busy", int'(out_busy), 1);
        chk("hold_timeout", int'(out_timeout), 0);
        chk("hold_no_done", n_done - d0, 0);
        stray_ack = 1'b1;
        withhold  = 1'b0;
        repeat (2) @(negedge in_clk);
        stray_ack = 1'b0;
        wait_done(20, "hold");
        @(negedge in_clk);
        chk("hold_strobes", n_strb - s0, 3);
        chk("hold_done_count", n_done - d0, 1);
        chk("hold_queue_empty", exp_q.size(), 0);
`endif

        repeat (3) @(negedge in_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 The block SHALL have parameter DATA_W, default 6, giving the word width driven to the downstream memory stage.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 15, giving the number of cycles to wait for an acknowledge.
REQ-003 The block SHALL have port in_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port in_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_start, input, 1 bit: begin a burst, sampled only in IDLE.
REQ-006 The block SHALL have port in_mode, input, 2 bits: pattern select, latched at start.
REQ-007 The block SHALL have port in_count, input, 8 bits: number of words in the burst, latched at start.
REQ-008 The block SHALL have port in_wrt_rd, input, 1 bit: write acknowledge from the downstream memory stage.
REQ-009 The block SHALL have port out_data, output, DATA_W bits: the current pattern word.
REQ-010 The block SHALL have port out_wrt_en, output, 1 bit: a one-cycle write strobe to the memory stage.
REQ-011 The block SHALL have port out_busy, output, 1 bit: high in any state other than IDLE.
REQ-012 The block SHALL have port out_done, output, 1 bit: a one-cycle pulse at burst end.
REQ-013 The block SHALL have port out_timeout, output, 1 bit: sticky acknowledge-timeout flag.

Function
REQ-014 The FSM SHALL have the states IDLE, WRITE, WAIT_ACK and DONE.
REQ-015 In IDLE with in_start=1, the block SHALL latch in_mode and in_count, load the pattern seed and clear out_timeout.
  - count=0: the next state SHALL be DONE, with no write issued.
  - otherwise: the next state SHALL be WRITE.
REQ-016 WRITE SHALL drive out_wrt_en=1 for exactly one cycle, then go to WAIT_ACK.
REQ-017 out_data SHALL be registered, and SHALL stay stable from WRITE until the acknowledge is accepted.
REQ-018 In WAIT_ACK with in_wrt_rd=1, the block SHALL advance the pattern and decrement the remaining count.
  - remaining count reaches 0: next state DONE.
  - otherwise: next state WRITE.
  - peak throughput: one word per 2 cycles.
REQ-019 in_wrt_rd seen outside WAIT_ACK SHALL be ignored.
REQ-020 DONE SHALL assert out_done for one cycle, then return to IDLE.
REQ-021 in_start SHALL be ignored while out_busy=1.
REQ-022 Patterns (seed shown first):
  - mode 0: counter 0,1,2,..., wrapping 63 to 0.
  - mode 1: walking one 000001, 000010, ..., 100000, 000001.
  - mode 2: LFSR with seed 000001, next = {d[4:0], d[5]^d[4]}, never all-zero.
  - mode 3: alternating 101010, 010101.
REQ-023 The 8-bit remaining counter SHALL never wrap, because a count of 0 exits before any write.

Reset
REQ-024 While in_rst=1 at a clock edge, the block SHALL go to IDLE and set all of the following to 0:
  - out_data, out_wrt_en, out_busy, out_done, out_timeout;
  - all internal counters.
REQ-025 Reset mid-burst SHALL abort immediately, and no out_done pulse SHALL be issued.

Configuration
REQ-026 With macro PATTERN_GEN_TIMEOUT_EN defined, the block SHALL run an acknowledge timeout:
  - a cycle counter SHALL run in WAIT_ACK, cleared on entry;
  - after TIMEOUT_CYC cycles without in_wrt_rd, out_timeout SHALL be set to 1 and the FSM SHALL go to DONE;
  - the remaining words SHALL be dropped.
REQ-027 Without PATTERN_GEN_TIMEOUT_EN, WAIT_ACK SHALL wait indefinitely, and out_timeout SHALL be tied to 0.

Verification
REQ-028 Mode 0, count=4, memory stage acking 1 cycle after each strobe -> out_data 0,1,2,3; 4 strobes 2 cycles apart; out_done pulses once; out_busy falls after DONE.
REQ-029 Mode 2, count=63 -> 63 distinct nonzero words; the first word is 000001.
REQ-030 count=0 with start -> no out_wrt_en; out_done pulses 2 cycles after start.
REQ-031 in_start pulsed mid-burst -> no effect; the word sequence is unchanged.
REQ-032 in_rst asserted during WAIT_ACK -> the next cycle is IDLE with all outputs 0; no out_done.
REQ-033 With PATTERN_GEN_TIMEOUT_EN, mode 1, count=3, ack withheld on word 2 -> out_timeout=1 after 15 cycles, one out_done pulse, and out_timeout cleared at the next start.
